// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg : shared constants for the divider issue/collect stage       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package div_pkg;

  localparam int         c_DEF_WIDTH   = 4;

  localparam logic [1:0] c_IDLE        = 2'd0;
  localparam logic [1:0] c_LAUNCH      = 2'd1;
  localparam logic [1:0] c_WAIT        = 2'd2;
  localparam logic [1:0] c_RESP        = 2'd3;

  // Every quotient bit is set in a divide-by-zero response.
  localparam logic       c_DZ_QUOT_BIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/div_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_watchdog : saturating WAIT-cycle counter, flags the cycle whose   |
// | increment reaches TIMEOUT. Rev 1.0                                    |
// +----------------------------------------------------------------------+
module div_watchdog #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W-1:0] c_LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] r_count;
  logic [TO_W-1:0] w_next;

  always_comb begin
    w_next = (r_count == c_LIMIT) ? r_count : r_count + TO_W'(1);
  end

  assign o_expired = i_en && (w_next == c_LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_issue_ctrl : issue/collect stage for the sequential divider core  |
// | with divide-by-zero screening and a hung-core watchdog. Rev 1.0       |
// +----------------------------------------------------------------------+
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH   = c_DEF_WIDTH,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_dividend,
  input  logic [WIDTH-1:0] s_divisor,
  output logic [WIDTH-1:0] core_data_1,
  output logic [WIDTH-1:0] core_data_2,
  output logic             core_start,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_q,
  input  logic [WIDTH-1:0] core_r,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_quot,
  output logic [WIDTH-1:0] m_rem,
  output logic             m_dz,
  output logic             m_err,
  output logic [1:0]       o_state
);

  localparam logic [WIDTH-1:0] c_DZ_QUOT = {WIDTH{c_DZ_QUOT_BIT}};

  logic [1:0]       r_state;
  logic             r_done_prev;
  logic [WIDTH-1:0] r_data_1;
  logic [WIDTH-1:0] r_data_2;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;
  logic             r_err;

  logic             w_done_edge;
  logic             w_wd_clr;
  logic             w_wd_en;
  logic             w_expired;

  // done_prev follows core_done through LAUNCH, so a done level left over
  // from the previous op must fall and rise again before it counts.
  assign w_done_edge = core_done & ~r_done_prev;
  assign w_wd_clr    = (r_state == c_LAUNCH);
  assign w_wd_en     = (r_state == c_WAIT) & ~w_done_edge;

  div_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= c_IDLE;
      r_done_prev <= 1'b0;
      r_data_1    <= '0;
      r_data_2    <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dz        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done_prev <= core_done;
      case (r_state)
        c_IDLE: begin
          if (s_valid) begin
            if (s_divisor != '0) begin
              r_data_1 <= s_divisor;
              r_data_2 <= s_dividend;
              r_state  <= c_LAUNCH;
            end else begin
              r_quot  <= c_DZ_QUOT;
              r_rem   <= s_dividend;
              r_dz    <= 1'b1;
              r_err   <= 1'b0;
              r_state <= c_RESP;
            end
          end
        end
        c_LAUNCH: begin
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          if (w_done_edge) begin
            r_quot  <= core_q;
            r_rem   <= core_r;
            r_dz    <= 1'b0;
            r_err   <= 1'b0;
            r_state <= c_RESP;
          end else if (w_expired) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
            r_err   <= 1'b1;
            r_state <= c_RESP;
          end
        end
        default: begin
          if (m_ready) begin
            r_state <= c_IDLE;
          end
        end
      endcase
    end
  end

  assign s_ready     = (r_state == c_IDLE);
  assign core_start  = (r_state == c_LAUNCH);
  assign m_valid     = (r_state == c_RESP);
  assign core_data_1 = r_data_1;
  assign core_data_2 = r_data_2;
  assign m_quot      = r_quot;
  assign m_rem       = r_rem;
  assign m_dz        = r_dz;
  assign m_err       = r_err;
  assign o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_issue_ctrl : directed self-checking bench for div_issue_ctrl   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_div_issue_ctrl;

  localparam int c_TIMEOUT = 15;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       err;
  } res_t;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_dividend;
  logic [3:0] s_divisor;
  logic [3:0] core_data_1;
  logic [3:0] core_data_2;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_q;
  logic [3:0] core_r;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_quot;
  logic [3:0] m_rem;
  logic       m_dz;
  logic       m_err;
  logic [1:0] o_state;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(4), .TIMEOUT(c_TIMEOUT), .TO_W(4)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_dividend(s_dividend), .s_divisor(s_divisor),
    .core_data_1(core_data_1), .core_data_2(core_data_2),
    .core_start(core_start), .core_done(core_done),
    .core_q(core_q), .core_r(core_r),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_quot(m_quot), .m_rem(m_rem), .m_dz(m_dz), .m_err(m_err),
    .o_state(o_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result an operation must produce, from the operands and whether the core answers.
  function automatic res_t model(input logic [3:0] a, input logic [3:0] b, input bit hung);
    res_t m;
    if (b == 4'd0) begin
      m.q = 4'hF; m.r = a; m.dz = 1'b1; m.err = 1'b0;
    end else if (hung) begin
      m.q = 4'd0; m.r = 4'd0; m.dz = 1'b0; m.err = 1'b1;
    end else begin
      m.q = a / b; m.r = a % b; m.dz = 1'b0; m.err = 1'b0;
    end
    return m;
  endfunction

  // done_at: WAIT cycle in which core_done rises (0 = never); stale: done high before launch,
  // falling in WAIT cycle 2; lag: cycles m_valid is held with m_ready low.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int done_at,
                        input bit stale, input int lag, input logic [3:0] lq,
                        input logic [3:0] lr, input bit ldz, input bit lerr, input int lat);
    int cyc;
    int nst;
    bit got;
    @(posedge clk); #1;
    exp_q.push_back(model(a, b, done_at == 0));
    core_done = stale;
    core_q = stale ? 4'hA : 4'h0;
    core_r = core_q;
    m_ready = (lag == 0);
    s_valid = 1'b1; s_dividend = a; s_divisor = b;
    @(negedge clk);
    chk("accept_s_ready", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    cyc = 0; nst = 0; got = 0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (core_start) begin
        nst++;
        chk("start_cycle", cyc, 0);
        chk("core_data_1", core_data_1, b);
        chk("core_data_2", core_data_2, a);
      end
      chk("busy_s_ready", s_ready, 0);
      if (m_valid) begin
        got = 1;
      end else begin
        chk("busy_state", o_state, (cyc == 0) ? 1 : 2);
        @(posedge clk); #1;
        cyc++;
        if (stale && cyc == 2) core_done = 1'b0;
        if (cyc == done_at) begin
          core_done = 1'b1; core_q = a / b; core_r = a % b;
        end
      end
    end
    chk("m_valid_seen", got, 1);
    chk("latency", cyc, lat);
    chk("lit_quot", m_quot, lq);
    chk("lit_rem", m_rem, lr);
    chk("lit_dz", m_dz, ldz);
    chk("lit_err", m_err, lerr);
    chk("start_count", nst, (b != 4'd0) ? 1 : 0);
    chk("resp_state", o_state, 3);
    for (int k = 1; k < lag; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", m_valid, 1);
      chk("hold_s_ready", s_ready, 0);
    end
    if (lag > 0) begin
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(negedge clk);
      chk("hold_valid", m_valid, 1);
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("post_m_valid", m_valid, 0);
    chk("post_s_ready", s_ready, 1);
    chk("post_state", o_state, 0);
  endtask

  initial begin
    i_rst = 1'b1; s_valid = 1'b0; s_dividend = 4'd0; s_divisor = 4'd0;
    core_done = 1'b0; core_q = 4'd0; core_r = 4'd0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", o_state, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_outputs", {core_data_1, core_data_2, m_quot, m_rem, m_dz, m_err}, 0);

    // Every cycle a result is offered it must equal the oldest expected result.
    fork
      forever begin
        @(negedge clk);
        if (!i_rst) begin
          chk("ready_valid_excl", s_ready & m_valid, 0);
          if (m_valid) begin
            if (exp_q.size() == 0) begin
              chk("spurious_m_valid", m_valid, 0);
            end else begin
              chk("res_quot", m_quot, exp_q[0].q);
              chk("res_rem", m_rem, exp_q[0].r);
              chk("res_dz", m_dz, exp_q[0].dz);
              chk("res_err", m_err, exp_q[0].err);
              if (m_ready) void'(exp_q.pop_front());
            end
          end
        end
      end
    join_none

    @(posedge clk); #1;
    i_rst = 1'b0;

    run_op(4'd15, 4'd2, 3, 1'b0, 0, 4'd7, 4'd1, 1'b0, 1'b0, 4);
    run_op(4'd9, 4'd0, 0, 1'b0, 0, 4'd15, 4'd9, 1'b1, 1'b0, 0);
    run_op(4'd12, 4'd5, 2, 1'b0, 5, 4'd2, 4'd2, 1'b0, 1'b0, 3);
    run_op(4'd6, 4'd3, 0, 1'b0, 0, 4'd0, 4'd0, 1'b0, 1'b1, c_TIMEOUT + 1);
    run_op(4'd10, 4'd3, c_TIMEOUT, 1'b0, 0, 4'd3, 4'd1, 1'b0, 1'b0, c_TIMEOUT + 1);
    run_op(4'd14, 4'd4, 6, 1'b1, 0, 4'd3, 4'd2, 1'b0, 1'b0, 7);
    run_op(4'd0, 4'd15, 1, 1'b0, 2, 4'd0, 4'd0, 1'b0, 1'b0, 2);

    // Reset in WAIT: the abandoned op must never produce a result.
    @(posedge clk); #1;
    core_done = 1'b0; m_ready = 1'b1;
    s_valid = 1'b1; s_dividend = 4'd13; s_divisor = 4'd4;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    core_done = 1'b1; core_q = 4'd3; core_r = 4'd1;
    @(negedge clk);
    chk("midrst_state", o_state, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_core_start", core_start, 0);
    chk("midrst_core_data_1", core_data_1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_result", m_valid, 0);
    end
    m_ready = 1'b0;
    run_op(4'd7, 4'd3, 2, 1'b0, 0, 4'd2, 4'd1, 1'b0, 1'b0, 3);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
